// File: rtl/hpsmem_fifo_reader_if.sv
// hpsmem_fifo_reader_if
//   Bundles the two data-path ports of the FIFO drain engine:
//     - FIFO read port   : fifo_empty, fifo_rd_en, fifo_data (data valid the
//                          cycle after fifo_rd_en)
//     - Avalon-MM master : avm_address, avm_write, avm_writedata,
//                          avm_byteenable, avm_waitrequest
//   master modport : the drain engine side
//   slave modport  : the FIFO / SDRAM bridge side
interface hpsmem_fifo_reader_if #(
    parameter int ADDR_W = 32
) ();
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [15:0]       fifo_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  avm_waitrequest,
        output fifo_rd_en,
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output avm_waitrequest,
        input  fifo_rd_en,
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable
    );
endinterface

// File: rtl/hpsmem_fifo_reader.sv
// hpsmem_fifo_reader
//   Drains a programmed number of 16-bit words from the HPS-memory staging
//   FIFO, packs pairs little-endian into 32-bit words and writes them to HPS
//   SDRAM as single Avalon-MM writes at incrementing word addresses.
//
//   Ports:
//     clk, reset     : single clock, synchronous active-high reset
//     start          : job command, sampled only in IDLE
//     base_addr      : first byte address (bits [1:0] forced to 0)
//     num_words      : number of 16-bit FIFO words to move
//     busy           : high whenever not IDLE
//     done           : one-cycle completion pulse
//     words_written  : 16-bit words accepted by the bus for current/last job
//     bus            : FIFO read port + Avalon-MM write master
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start
//   RD    | issue one FIFO read as soon as the FIFO is non-empty
//   CAP   | capture read data into low/high half of the write register
//   WR    | hold the Avalon write until waitrequest is low
//   FIN   | one-cycle done pulse
module hpsmem_fifo_reader #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      num_words,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      words_written,
    hpsmem_fifo_reader_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              half_q, half_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [LEN_W-1:0]  ww_q, ww_d;
    logic [LEN_W-1:0]  remaining_dec;
    logic              rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            half_q      <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            ww_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            half_q      <= half_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ww_q        <= ww_d;
        end
    end

    // Saturating decrement: remaining never goes below zero.
    always_comb begin
        remaining_dec = remaining_q;
        if (remaining_q != '0) begin
            remaining_dec = remaining_q - LEN_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        half_d      = half_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ww_d        = ww_q;
        rd_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ww_d = '0;
                    if (num_words != '0) begin
                        addr_d      = base_addr & ~ADDR_W'(3);
                        remaining_d = num_words;
                        half_d      = 1'b0;
                        state_d     = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end

            S_RD: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = S_CAP;
                end
            end

            S_CAP: begin
                remaining_d = remaining_dec;
                // Low-half capture also clears the upper lanes so a trailing
                // odd word goes out with writedata[31:16] = 0.
                if (!half_q) begin
                    wdata_d = {16'h0000, bus.fifo_data};
                end else begin
                    wdata_d = {bus.fifo_data, wdata_q[15:0]};
                end
                if (!half_q && (remaining_dec != '0)) begin
                    half_d  = 1'b1;
                    state_d = S_RD;
                end else begin
                    be_d    = half_q ? 4'b1111 : 4'b0011;
                    state_d = S_WR;
                end
            end

            S_WR: begin
                if (!bus.avm_waitrequest) begin
                    addr_d = addr_q + ADDR_W'(4);
                    ww_d   = ww_q + ((be_q == 4'b1111) ? LEN_W'(2) : LEN_W'(1));
                    if (remaining_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        half_d  = 1'b0;
                        state_d = S_RD;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_FIN);
    assign words_written      = ww_q;
    assign bus.fifo_rd_en     = rd_en;
    assign bus.avm_write      = (state_q == S_WR);
    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_byteenable = be_q;

endmodule

// File: tb/tb_hpsmem_fifo_reader.sv
module tb_hpsmem_fifo_reader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic [15:0] words_written;

    hpsmem_fifo_reader_if #(.ADDR_W(32)) bus ();

    hpsmem_fifo_reader #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .bus           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    wr_t         exp_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] job_data[$];
    bit          mon_en = 0;

    // Sampled DUT status for the current cycle (taken at the negedge).
    logic        rd_prev, done_s, busy_s, wr_s;
    logic [15:0] ww_s;

    // Stimulus knobs consumed by tick().
    int          empty_pct = 0;
    int          wait_pct  = 0;
    int          stall_left = 0;
    bit          gap_arm = 0;
    int          gap_len = 0;
    int          gap_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock: sample status mid-cycle, then after the edge update the
    // FIFO model (data valid the cycle after a read) and waitrequest.
    task automatic tick();
        @(negedge clk);
        rd_prev = bus.fifo_rd_en;
        done_s  = done;
        busy_s  = busy;
        ww_s    = words_written;
        wr_s    = bus.avm_write;
        @(posedge clk);
        #1;
        if (rd_prev === 1'b1) begin
            if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
            else                   bus.fifo_data = 16'hDEAD;
            if (gap_arm) begin
                gap_cnt = gap_len;
                gap_arm = 0;
            end
        end else begin
            bus.fifo_data = 16'($urandom);
            if (gap_cnt > 0) gap_cnt--;
        end
        bus.fifo_empty = (fifo_q.size() == 0) || (gap_cnt > 0) ||
                         (int'($urandom_range(0, 99)) < empty_pct);
        if (stall_left > 0 && bus.avm_write === 1'b1) begin
            bus.avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            bus.avm_waitrequest = (int'($urandom_range(0, 99)) < wait_pct);
        end
    endtask

    // Reference model: the whole job as a list of 32-bit writes.
    task automatic model_job(input logic [31:0] base, input int n);
        wr_t w;
        logic [31:0] a;
        a = {base[31:2], 2'b00};
        for (int i = 0; i < n; i += 2) begin
            w.addr = a;
            if (i + 1 < n) begin
                w.data = {job_data[i+1], job_data[i]};
                w.be   = 4'b1111;
            end else begin
                w.data = {16'h0000, job_data[i]};
                w.be   = 4'b0011;
            end
            exp_q.push_back(w);
            a = a + 32'd4;
        end
    endtask

    task automatic run_job(input string tag, input logic [31:0] base, input int n,
                           input int exp_lat, input int exp_wr, input bit mid_start);
        int lat, wr_cycles, rd_cnt;
        while (job_data.size() < n) job_data.push_back(16'($urandom));
        for (int i = 0; i < n; i++) fifo_q.push_back(job_data[i]);
        model_job(base, n);
        base_addr = base;
        num_words = 16'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; wr_cycles = 0; rd_cnt = 0;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (k == 1) chk({tag, "_busy_first"}, 64'(busy_s), 64'd1);
            if (wr_s === 1'b1) wr_cycles++;
            if (rd_prev === 1'b1) rd_cnt++;
            if (mid_start && k == 2) begin
                start     = 1'b1;
                num_words = 16'd0;
                base_addr = 32'hDEAD_0000;
            end
            if (mid_start && k == 3) begin
                start     = 1'b0;
                num_words = 16'(n);
            end
            if (done_s === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", tag);
        end
        if (exp_lat >= 0) chk({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
        if (exp_wr >= 0)  chk({tag, "_write_cycles"}, 64'(wr_cycles), 64'(exp_wr));
        chk({tag, "_fifo_reads"}, 64'(rd_cnt), 64'(n));
        chk({tag, "_words_written_at_done"}, 64'(ww_s), 64'(n));
        tick();
        chk({tag, "_busy_after_done"}, 64'(busy_s), 64'd0);
        chk({tag, "_words_written_held"}, 64'(ww_s), 64'(n));
        chk({tag, "_writes_outstanding"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_fifo_leftover"}, 64'(fifo_q.size()), 64'd0);
        exp_q.delete();
        fifo_q.delete();
        job_data.delete();
    endtask

    // Scoreboard monitor: protocol checks and write comparison.
    initial begin : monitor
        logic        prev_rd, prev_wr, prev_wait;
        logic [31:0] prev_addr, prev_data;
        logic [3:0]  prev_be;
        wr_t         e;
        prev_rd = 0; prev_wr = 0; prev_wait = 0;
        prev_addr = '0; prev_data = '0; prev_be = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.fifo_rd_en === 1'b1) begin
                    chk("rd_en_while_empty", 64'(bus.fifo_empty), 64'd0);
                    chk("rd_en_back_to_back", 64'(prev_rd), 64'd0);
                end
                if (bus.avm_write === 1'b1 && prev_wr && prev_wait) begin
                    chk("stall_hold_addr", 64'(bus.avm_address), 64'(prev_addr));
                    chk("stall_hold_data", 64'(bus.avm_writedata), 64'(prev_data));
                    chk("stall_hold_be", 64'(bus.avm_byteenable), 64'(prev_be));
                end
                if (bus.avm_write === 1'b1 && bus.avm_waitrequest === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_write: got write 0x%08h @0x%08h, expected none",
                                 bus.avm_writedata, bus.avm_address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 64'(bus.avm_address), 64'(e.addr));
                        chk("write_data", 64'(bus.avm_writedata), 64'(e.data));
                        chk("write_be", 64'(bus.avm_byteenable), 64'(e.be));
                    end
                end
            end
            prev_rd   = (bus.fifo_rd_en === 1'b1);
            prev_wr   = (bus.avm_write === 1'b1);
            prev_wait = (bus.avm_waitrequest === 1'b1);
            prev_addr = bus.avm_address;
            prev_data = bus.avm_writedata;
            prev_be   = bus.avm_byteenable;
        end
    end

    initial begin : stimulus
        int lat;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = '0;
        bus.avm_waitrequest = 1'b0;
        repeat (3) tick();

        chk("reset_busy", 64'(busy_s), 64'd0);
        chk("reset_done", 64'(done_s), 64'd0);
        chk("reset_rd_en", 64'(rd_prev), 64'd0);
        chk("reset_write", 64'(wr_s), 64'd0);
        chk("reset_words_written", 64'(ww_s), 64'd0);
        chk("reset_address", 64'(bus.avm_address), 64'd0);
        chk("reset_writedata", 64'(bus.avm_writedata), 64'd0);
        chk("reset_byteenable", 64'(bus.avm_byteenable), 64'd0);
        reset = 1'b0;
        mon_en = 1;
        tick();

        job_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_job("four_words", 32'h0000_1000, 4, 11, 2, 0);

        job_data = '{16'h000A, 16'h000B, 16'h000C};
        run_job("odd_count", 32'h0000_2000, 3, 9, 2, 0);

        stall_left = 3;
        run_job("stall3", 32'h0000_3000, 2, 9, 4, 0);

        gap_arm = 1; gap_len = 5;
        run_job("empty_gap", 32'h0000_4002, 2, 10, 1, 0);

        run_job("zero_words", 32'h0000_5000, 0, 1, 0, 0);

        run_job("start_while_busy", 32'h0000_5100, 6, 16, 3, 0 | 1);

        run_job("addr_wrap", 32'hFFFF_FFFA, 6, 16, 3, 0);

        // Reset while a write is stalled.
        stall_left = 1000;
        job_data = '{16'hAAAA, 16'h5555};
        for (int i = 0; i < 2; i++) fifo_q.push_back(job_data[i]);
        base_addr = 32'h0000_7000;
        num_words = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (wr_s === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("reset_test_reached_wr", 64'(lat), 64'd5);
        reset = 1'b1;
        tick();
        tick();
        chk("midreset_write", 64'(wr_s), 64'd0);
        chk("midreset_busy", 64'(busy_s), 64'd0);
        chk("midreset_done", 64'(done_s), 64'd0);
        reset = 1'b0;
        stall_left = 0;
        exp_q.delete();
        fifo_q.delete();
        job_data.delete();
        tick();

        job_data = '{16'hBEEF, 16'hCAFE, 16'h0123, 16'h4567};
        run_job("after_reset", 32'h0000_6000, 4, 11, 2, 0);

        for (int j = 0; j < 10; j++) begin
            empty_pct = int'($urandom_range(0, 30));
            wait_pct  = int'($urandom_range(0, 40));
            run_job("random", $urandom, int'($urandom_range(0, 11)), -1, -1, 0);
        end
        empty_pct = 0;
        wait_pct  = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hpsmem_fifo_reader.md
# hpsmem_fifo_reader

Drain engine on the consumer side of the 16-bit HPS-memory staging FIFO. On a `start` command it pulls a programmed number of 16-bit words out of the FIFO through its `rd_en`/`data_out` port, packs pairs little-endian into 32-bit words, and writes them to HPS SDRAM as single Avalon-MM master writes at incrementing addresses. It sits between the FIFO and the FPGA-to-HPS SDRAM bridge, and reports progress and completion to the control logic.

## Interface
- `ADDR_W`, 32, byte address width of the Avalon-MM master.
- `LEN_W`, 16, width of the word-count and progress counters.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first byte address; bits [1:0] are ignored and treated as 0.
- `num_words`  in  LEN_W  number of 16-bit FIFO words to transfer.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `words_written`  out  LEN_W  16-bit words accepted by the bus in the current or last job.
- `fifo_empty`  in  1  FIFO has no readable word.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_data`  in  16  FIFO read data, valid the cycle after `fifo_rd_en`.
- `avm_address`  out  ADDR_W  write byte address.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  32  packed data.
- `avm_byteenable`  out  4  byte lanes.
- `avm_waitrequest`  in  1  slave stall.

## Operation
- FSM states: IDLE, RD, CAP, WR, FIN.
- IDLE:
  - `start`=1 with `num_words`≠0: latch `base_addr` into the address register, load `remaining`=`num_words`, clear `half` and `words_written`, then go to RD.
  - `start`=1 with `num_words`=0: clear `words_written`, then go to FIN.
  - `start` is ignored in every other state.
- RD: if `fifo_empty`=0, assert `fifo_rd_en` for this cycle and go to CAP. Otherwise stay in RD with `fifo_rd_en`=0.
- CAP:
  - Capture `fifo_data` into the low half (`half`=0) or high half (`half`=1) of the write register, and decrement `remaining`.
  - If `half`=0 and the new `remaining`≠0: set `half`=1 and go to RD.
  - Otherwise go to WR. `avm_byteenable` is 4'b1111 if the high half is filled, else 4'b0011 with `writedata[31:16]`=0.
- WR:
  - Hold `avm_write`=1 with address, data and byteenable stable until a cycle with `avm_waitrequest`=0.
  - On acceptance: address += 4; `words_written` += 2 (4'b1111) or += 1 (4'b0011).
  - Then go to FIN if `remaining`=0; otherwise clear `half` and go to RD.
- FIN: `done`=1 for exactly this cycle, then go to IDLE.
- Arithmetic:
  - Address adds wrap modulo 2^ADDR_W.
  - `remaining` never decrements below 0.
  - An odd `num_words` ends with one 2-byte write.
- `fifo_rd_en` is never asserted while `fifo_empty`=1, and never in two consecutive cycles.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `fifo_rd_en`, `avm_write` = 0.
  - `avm_address`, `avm_writedata`, `words_written` = 0.
  - `avm_byteenable` = 0.
- Reset mid-job takes effect at the next edge: `avm_write` drops even if `avm_waitrequest`=1, and the partial word is discarded. FIFO words already read are lost; the FIFO is not rewound.
- Edge sequence for `start` sampled at edge N with the FIFO non-empty and waitrequest low:
  - `fifo_rd_en` high in cycle N+1.
  - Capture in N+2; second read in N+3; capture in N+4.
  - `avm_write` high in N+5, accepted at the end of N+5.
  - Next RD (or FIN) in N+6.
- Steady state: 5 cycles per 32-bit write plus one cycle per waitrequest stall and per cycle spent empty in RD.
- `num_words`=0: `done` high in cycle N+1, `busy` high only in N+1.
- `busy` falls in the cycle after the `done` cycle. A `start` in that cycle begins a new job.
- `words_written` updates in the cycle after acceptance and holds its value in IDLE until the next `start`.

## Test plan
- Reset, then `base_addr`=0x1000, `num_words`=4, FIFO holds 0x1111, 0x2222, 0x3333, 0x4444, no stalls:
  - writes 0x22221111 @0x1000 and 0x44443333 @0x1004, both be=1111.
  - `done` at N+11; `words_written`=4.
- `num_words`=3, data 0xA, 0xB, 0xC:
  - writes 0x000B000A @base (be=1111) and 0x0000000C @base+4 (be=0011).
  - `words_written`=3.
- `avm_waitrequest` held high for 3 cycles on the first write:
  - address, data and be stay stable and `avm_write` stays 1 for 4 cycles.
  - exactly one write counted.
- `fifo_empty`=1 for 5 cycles between the first and second word:
  - no `fifo_rd_en` while empty; data packed correctly once the FIFO refills.
- `num_words`=0 → `done` pulse at N+1, no FIFO reads or bus writes. A `start` during busy is ignored (`words_written` is unaffected).
- Assert `reset` in WR with `avm_waitrequest`=1:
  - `avm_write` is 0 in the next cycle; `busy`=0, `done`=0.
  - a new job then runs normally from the new `base_addr`.
